// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank read path.
// Requester indices name the clients of the single bank read port.
package regbank_pkg;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 16;
    localparam int NREQ = 3;
    localparam int IDW  = 2;

    typedef logic [IDW-1:0] req_id_t;

    localparam req_id_t REQ_OPA = 2'd0;
    localparam req_id_t REQ_OPB = 2'd1;
    localparam req_id_t REQ_DBG = 2'd2;

endpackage

// File: rtl/regbank_read_arbiter_rr.sv
// Rotating-priority search: the first asserted request at or after ptr wins.
// Output is one-hot, or all zero when disabled or nothing is requesting.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    // Walk the requesters starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_read_arbiter.sv
// Round-robin sharing of the register-bank read port with a registered,
// id-tagged result stage and same-cycle write bypass.
module regbank_read_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   gnt,
    output logic [AW-1:0]     mux_sel,
    input  logic [DW-1:0]     mux_out,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [IDW-1:0]    rd_id,
    output logic [DW-1:0]     rd_data
);

    import regbank_pkg::*;

    logic            rd_valid_q, rd_valid_d;
    logic [IDW-1:0]  rd_id_q, rd_id_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [AW-1:0]   sel_q, sel_d;

    logic            stall;
    logic            any_gnt;
    logic [IDW-1:0]  win;
    logic [AW-1:0]   win_addr;
    logic            bypass;

    assign stall = rd_valid_q && !rd_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .en  (!stall && !rst),
        .gnt (gnt)
    );

    // Decode the one-hot grant into the winner index and its address.
    always_comb begin
        win      = '0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win      = IDW'(i);
                win_addr = req_addr[i*AW +: AW];
            end
        end
    end

    assign any_gnt = |gnt;
    assign mux_sel = any_gnt ? win_addr : sel_q;
    assign bypass  = wr_en && (wr_addr == mux_sel);

    // Next state of the result stage, pointer and select hold register.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_id_d    = rd_id_q;
        rd_data_d  = rd_data_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        if (any_gnt) begin
            rd_valid_d = 1'b1;
            rd_id_d    = win;
            rd_data_d  = bypass ? wr_data : mux_out;
            ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            sel_d      = win_addr;
        end else if (!stall) begin
            rd_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_data_q  <= '0;
            ptr_q      <= '0;
            sel_q      <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_data_q  <= rd_data_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Directed bench for regbank_read_arbiter with a behavioural register bank.
// Vector table plus hand-written stall and mid-stream reset sequences.
module tb_regbank_read_arbiter;

    import regbank_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] req_addr;
    logic [2:0]  gnt;
    logic [3:0]  mux_sel;
    logic [31:0] mux_out;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [1:0]  rd_id;
    logic [31:0] rd_data;

    logic [31:0] bank [16];

    int checks;
    int failures;

    regbank_read_arbiter #(
        .NREQ (3),
        .DW   (32),
        .AW   (4),
        .IDW  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .mux_out  (mux_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_id    (rd_id),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: combinational read, write on the clock edge.
    assign mux_out = bank[mux_sel];
    always @(posedge clk) begin
        if (wr_en) bank[wr_addr] <= wr_data;
    end

    typedef struct {
        logic [2:0]  req;
        logic [3:0]  a0, a1, a2;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic [2:0]  gnt;
        logic [3:0]  sel;
        logic        v;
        logic [1:0]  id;
        logic [31:0] data;
        logic        chkd;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic [2:0] r, input logic [3:0] a0, a1, a2,
        input logic we, input logic [3:0] wa, input logic [31:0] wd,
        input logic rdy, input logic [2:0] g, input logic [3:0] s,
        input logic v, input logic [1:0] id, input logic [31:0] d,
        input logic cd);
        vec_t t;
        t.req = r; t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.we = we; t.wa = wa; t.wd = wd; t.rdy = rdy;
        t.gnt = g; t.sel = s; t.v = v; t.id = id;
        t.data = d; t.chkd = cd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [3:0] a0, a1, a2,
                         input logic we, input logic [3:0] wa,
                         input logic [31:0] wd, input logic rdy);
        req      = r;
        req_addr = {a2, a1, a0};
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_ready = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) bank[i] = '0;
        bank[3] = 32'hAAAA_0003;
        bank[5] = 32'h1234_5678;
        bank[9] = 32'hBBBB_0009;

        vt[0]  = mk(3'b001, 5, 0, 0, 0, 0, 0, 1, 3'b001, 5,
                    1, REQ_OPA, 32'h1234_5678, 1);
        vt[1]  = mk(3'b111, 3, 9, 5, 0, 0, 0, 1, 3'b010, 9,
                    1, REQ_OPB, 32'hBBBB_0009, 1);
        vt[2]  = mk(3'b111, 3, 9, 5, 0, 0, 0, 1, 3'b100, 5,
                    1, REQ_DBG, 32'h1234_5678, 1);
        vt[3]  = mk(3'b111, 3, 9, 5, 0, 0, 0, 1, 3'b001, 3,
                    1, REQ_OPA, 32'hAAAA_0003, 1);
        vt[4]  = mk(3'b111, 3, 9, 5, 0, 0, 0, 1, 3'b010, 9,
                    1, REQ_OPB, 32'hBBBB_0009, 1);
        vt[5]  = mk(3'b111, 3, 9, 5, 0, 0, 0, 1, 3'b100, 5,
                    1, REQ_DBG, 32'h1234_5678, 1);
        vt[6]  = mk(3'b010, 0, 7, 0, 1, 7, 32'hDEAD_BEEF, 1, 3'b010, 7,
                    1, REQ_OPB, 32'hDEAD_BEEF, 1);
        vt[7]  = mk(3'b100, 0, 0, 10, 1, 8, 32'hCAFE_F00D, 1, 3'b100, 10,
                    1, REQ_DBG, 32'h0, 1);
        vt[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 10,
                    0, 0, 32'h0, 0);
        vt[9]  = mk(3'b001, 8, 0, 0, 0, 0, 0, 1, 3'b001, 8,
                    1, REQ_OPA, 32'hCAFE_F00D, 1);
        vt[10] = mk(3'b001, 7, 0, 0, 0, 0, 0, 1, 3'b001, 7,
                    1, REQ_OPA, 32'hDEAD_BEEF, 1);
        vt[11] = mk(3'b101, 3, 0, 9, 0, 0, 0, 1, 3'b100, 9,
                    1, REQ_DBG, 32'hBBBB_0009, 1);
        vt[12] = mk(3'b110, 0, 5, 3, 0, 0, 0, 1, 3'b010, 5,
                    1, REQ_OPB, 32'h1234_5678, 1);

        rst = 1'b1;
        drive(3'b000, 0, 0, 0, 0, 0, 0, 1);
        #12;
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_id", 32'(rd_id), 32'h0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(mux_sel), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].req, vt[i].a0, vt[i].a1, vt[i].a2,
                  vt[i].we, vt[i].wa, vt[i].wd, vt[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("v%0d_sel", i), 32'(mux_sel), 32'(vt[i].sel));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vt[i].v));
            if (vt[i].chkd) begin
                chk($sformatf("v%0d_id", i), 32'(rd_id), 32'(vt[i].id));
                chk($sformatf("v%0d_data", i), rd_data, vt[i].data);
            end
        end

        // Stall: result held, no grant, select held, pointer frozen at 2.
        for (int c = 0; c < 3; c++) begin
            drive(3'b111, 3, 9, 3, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("stall%0d_gnt", c), 32'(gnt), 32'h0);
            chk($sformatf("stall%0d_sel", c), 32'(mux_sel), 32'd5);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c), 32'(rd_valid), 32'h1);
            chk($sformatf("stall%0d_id", c), 32'(rd_id), 32'(REQ_OPB));
            chk($sformatf("stall%0d_data", c), rd_data, 32'h1234_5678);
        end
        drive(3'b111, 3, 9, 3, 0, 0, 0, 1);
        @(negedge clk);
        chk("resume_gnt", 32'(gnt), 32'b100);
        chk("resume_sel", 32'(mux_sel), 32'd3);
        @(posedge clk);
        #1;
        chk("resume_valid", 32'(rd_valid), 32'h1);
        chk("resume_id", 32'(rd_id), 32'(REQ_DBG));
        chk("resume_data", rd_data, 32'hAAAA_0003);

        // Asynchronous reset between edges with a result in flight.
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rd_valid), 32'h0);
        chk("arst_data", rd_data, 32'h0);
        chk("arst_id", 32'(rd_id), 32'h0);
        chk("arst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b110, 0, 9, 5, 0, 0, 0, 1);
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b010);
        chk("post_rst_sel", 32'(mux_sel), 32'd9);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(rd_valid), 32'h1);
        chk("post_rst_id", 32'(rd_id), 32'(REQ_OPB));
        chk("post_rst_data", rd_data, 32'hBBBB_0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_read_arbiter.md
# regbank_read_arbiter

Shares the single read port of the 16-entry, 32-bit register bank (driven through the bank's 16:1 read mux) among up to NREQ requesters (operand-A fetch, operand-B fetch, debug port). Each cycle it grants one requester by round-robin and drives the mux select. It returns the read data one cycle later, tagged with the requester ID, through a valid/ready output stage. It forwards same-cycle register writes so that a read never returns stale data.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..4)
- DW, 32, data width
- AW, 4, register address width (16 registers)
- IDW, 2, requester ID width (ceil(log2(NREQ)), minimum 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester read request, level
- req_addr  in  NREQ*AW  register address; requester i occupies bits [i*AW +: AW]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the accepted request
- mux_sel  out  AW  select to the register-bank read mux
- mux_out  in  DW  read-mux output, combinational from mux_sel
- wr_en  in  1  register-bank write strobe; the bank updates on this clk edge
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- rd_valid  out  1  read result valid
- rd_ready  in  1  consumer accepts the result
- rd_id  out  IDW  index of the requester that owns rd_data
- rd_data  out  DW  read result

## Operation
- Reset values: gnt=0, mux_sel=0, rd_valid=0, rd_id=0, rd_data=0, round-robin pointer ptr=0.
- Output stage: one register holding {rd_valid, rd_id, rd_data}.
- Stall: the stage is stalled when rd_valid && !rd_ready. While stalled:
  - gnt=0;
  - output stage and ptr hold;
  - mux_sel holds its last value.
- Arbitration, when not stalled:
  - winner = first asserted req[i] searching i = ptr, ptr+1, …, wrapping modulo NREQ;
  - gnt[winner]=1;
  - mux_sel = winner's req_addr, combinationally.
- No request: gnt=0, mux_sel holds its registered last value, ptr unchanged. At the edge, rd_valid←0 if the stage was empty or was accepted this cycle.
- On a grant, at the clock edge:
  - rd_valid←1, rd_id←winner;
  - rd_data←wr_data if wr_en && wr_addr==mux_sel (write bypass), otherwise mux_out;
  - ptr←(winner+1) mod NREQ.
- Requester handshake:
  - a requester holds req and req_addr stable until it sees gnt;
  - req held after gnt is a new request and competes again under round-robin.
- Fairness: a requester that holds req continuously is granted within NREQ non-stalled cycles.
- Register 0 receives no special treatment; it reads whatever the bank holds.
- Addresses are unsigned AW bits and are never out of range. Indices ≥NREQ never win.

## Timing
- Grant latency: 0 cycles (same cycle as req when not stalled).
- Read latency: rd_valid asserts 1 cycle after gnt.
- Throughput: one read per cycle when rd_ready is held high. Accept and grant in the same cycle is allowed: rd_valid && rd_ready && req → new data on the next edge, no bubble.
- Simultaneous write and read to the same register: returns the new value (bypass). A write to a different register does not affect rd_data.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). In-flight data is discarded and no rd_valid is issued for it. Requesters must re-request after rst falls.
- First cycle after reset release: ptr=0, so requester 0 has priority.

## Structure
- Shared package regbank_pkg holds:
  - DW, AW, NREG=16;
  - the requester ID type;
  - named requester indices (REQ_OPA=0, REQ_OPB=1, REQ_DBG=2).
- Sub-module rr_arbiter (parameter NREQ; inputs req, ptr, en; output one-hot gnt) performs the rotating priority search.
- The top level contains ptr, the output stage, the mux_sel hold register and the bypass compare.

## Test plan
- Single request: req=001, addr0=5, bank r5=0x1234_5678, rd_ready=1 → gnt=001 in the same cycle, mux_sel=5; next cycle rd_valid=1, rd_id=0, rd_data=0x1234_5678.
- All three requesting continuously, rd_ready=1 from reset → grant order 0,1,2,0,1,2 across consecutive cycles; rd_valid stays high with no bubbles.
- Bypass: grant to addr 7 while wr_en=1, wr_addr=7, wr_data=0xDEAD_BEEF, bank holds 0 → rd_data=0xDEAD_BEEF. Repeat with wr_addr=8 → rd_data=0.
- Stall: rd_ready=0 for 3 cycles while rd_valid=1 → rd_data and rd_id stable, gnt=0, ptr unchanged. After rd_ready=1, the next grant resumes at the held ptr.
- Reset mid-stream: assert rst asynchronously between edges while rd_valid=1 → rd_valid, rd_data and gnt drop to 0 immediately. After release with req=110, requester 1 is granted first.
